// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared register offsets, CTRL field layout, Wishbone slave
// FSM encoding and a byte-lane merge helper for the wb_timer block.
package wb_timer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADR_W      = 4;
  localparam int unsigned SEL_W      = DATA_W / 8;
  localparam int unsigned PRESCALE_W = 8;

  // Default register byte offsets
  localparam logic [31:0] TIMER_CTRL_OFFSET  = 32'h0;
  localparam logic [31:0] TIMER_LOAD_OFFSET  = 32'h4;
  localparam logic [31:0] TIMER_VALUE_OFFSET = 32'h8;
  localparam logic [31:0] TIMER_CLEAR_OFFSET = 32'hC;

  // CTRL bit-field positions
  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PERIODIC_BIT = 1;
  localparam int unsigned CTRL_IE_BIT       = 2;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;
  localparam int unsigned CTRL_PRESCALE_MSB = 15;

  // Implemented CTRL bits; everything else reads 0 and ignores writes
  localparam logic [DATA_W-1:0] CTRL_WMASK = 32'h0000_FF07;

  // Wishbone slave FSM encoding, common to the SoC's simple slaves
  typedef enum logic [2:0] {
    WB_IDLE  = 3'd0,
    WB_READ  = 3'd1,
    WB_WRITE = 3'd2,
    WB_ACK   = 3'd3,
    WB_DONE  = 3'd4
  } wb_state_e;

  // Replace the byte lanes of old_val selected by sel with those of new_val
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [SEL_W-1:0]  sel
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_core.sv
// wb_timer_core: prescaler, down-counter, expiry/pending and interrupt logic.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ctrl_we/_wdata      CTRL write strobe and already byte-merged value
//   i_load_we/_wdata      LOAD write strobe and already byte-merged value
//   i_clear               clear pending strobe
//   o_ctrl/o_load/o_value register contents for readback
//   o_pending             sticky expiry flag
//   o_irq                 registered pending & IE
module wb_timer_core
  import wb_timer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ctrl_we,
  input  logic [DATA_W-1:0] i_ctrl_wdata,
  input  logic              i_load_we,
  input  logic [DATA_W-1:0] i_load_wdata,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_value,
  output logic              o_pending,
  output logic              o_irq
);

  logic [DATA_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     load_q, load_d;
  logic [DATA_W-1:0]     value_q, value_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  pending_q, pending_d;
  logic                  irq_q, irq_d;

  logic en_c, periodic_c, ie_c, tick_c, expire_c;

  assign en_c       = ctrl_q[CTRL_EN_BIT];
  assign periodic_c = ctrl_q[CTRL_PERIODIC_BIT];
  assign ie_c       = ctrl_q[CTRL_IE_BIT];
  assign tick_c     = en_c && (pre_cnt_q == ctrl_q[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB]);
  assign expire_c   = tick_c && (value_q == '0);

  // Next-state: bus writes take priority over counter activity
  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    pending_d = pending_q;
    irq_d     = pending_q & ie_c;

    if (i_ctrl_we || i_load_we || !en_c || tick_c) pre_cnt_d = '0;

    if (i_ctrl_we)                    ctrl_d = i_ctrl_wdata & CTRL_WMASK;
    else if (expire_c && !periodic_c) ctrl_d[CTRL_EN_BIT] = 1'b0;

    if (i_load_we) load_d = i_load_wdata;

    // Zero is expiry rather than a decrement, so VALUE never wraps
    if (i_load_we) begin
      value_d = i_load_wdata;
    end else if (tick_c) begin
      if (value_q != '0)   value_d = value_q - DATA_W'(1);
      else if (periodic_c) value_d = load_q;
    end

    // Expiry beats a simultaneous clear
    if (expire_c)     pending_d = 1'b1;
    else if (i_clear) pending_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      pre_cnt_q <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      pre_cnt_q <= pre_cnt_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign o_ctrl    = ctrl_q;
  assign o_load    = load_q;
  assign o_value   = value_q;
  assign o_pending = pending_q;
  assign o_irq     = irq_q;

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone slave wrapper around the programmable down-counter timer.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_wb_dat/adr/stb/cyc/wen/sel     Wishbone request (held until ack)
//   o_wb_dat                         registered read data
//   o_wb_ack                         one-cycle acknowledge
//   o_irq                            level interrupt, held until cleared
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] TIMER_CTRL_REGISTER  = TIMER_CTRL_OFFSET,
  parameter logic [31:0] TIMER_LOAD_REGISTER  = TIMER_LOAD_OFFSET,
  parameter logic [31:0] TIMER_VALUE_REGISTER = TIMER_VALUE_OFFSET,
  parameter logic [31:0] TIMER_CLEAR_REGISTER = TIMER_CLEAR_OFFSET
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_wb_dat,
  input  logic [ADR_W-1:0]  i_wb_adr,
  input  logic              i_wb_stb,
  input  logic              i_wb_cyc,
  input  logic              i_wb_wen,
  input  logic [SEL_W-1:0]  i_wb_sel,
  output logic [DATA_W-1:0] o_wb_dat,
  output logic              o_wb_ack,
  output logic              o_irq
);

  localparam logic [ADR_W-1:0] CTRL_ADR  = ADR_W'(TIMER_CTRL_REGISTER);
  localparam logic [ADR_W-1:0] LOAD_ADR  = ADR_W'(TIMER_LOAD_REGISTER);
  localparam logic [ADR_W-1:0] VALUE_ADR = ADR_W'(TIMER_VALUE_REGISTER);
  localparam logic [ADR_W-1:0] CLEAR_ADR = ADR_W'(TIMER_CLEAR_REGISTER);

  wb_state_e state_q;

  logic [DATA_W-1:0] ctrl_c, load_c, value_c, rdata_c;
  logic              pending_c, wr_c;
  logic              ctrl_we_c, load_we_c, clear_c;

  // Write strobes are only live in WRITE; adr/dat/sel are held by the master
  assign wr_c      = (state_q == WB_WRITE);
  assign ctrl_we_c = wr_c && (i_wb_adr == CTRL_ADR);
  assign load_we_c = wr_c && (i_wb_adr == LOAD_ADR);
  assign clear_c   = wr_c && (i_wb_adr == CLEAR_ADR) && i_wb_sel[0] && i_wb_dat[0];

  // Read mux; unmapped addresses return 0
  always_comb begin
    rdata_c = '0;
    if      (i_wb_adr == CTRL_ADR)  rdata_c = ctrl_c;
    else if (i_wb_adr == LOAD_ADR)  rdata_c = load_c;
    else if (i_wb_adr == VALUE_ADR) rdata_c = value_c;
    else if (i_wb_adr == CLEAR_ADR) rdata_c = {{(DATA_W-1){1'b0}}, pending_c};
  end

  wb_timer_core u_core (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ctrl_we    (ctrl_we_c),
    .i_ctrl_wdata (byte_merge(ctrl_c, i_wb_dat, i_wb_sel)),
    .i_load_we    (load_we_c),
    .i_load_wdata (byte_merge(load_c, i_wb_dat, i_wb_sel)),
    .i_clear      (clear_c),
    .o_ctrl       (ctrl_c),
    .o_load       (load_c),
    .o_value      (value_c),
    .o_pending    (pending_c),
    .o_irq        (o_irq)
  );

  // Bus FSM: request -> READ/WRITE -> ACK (ack rises) -> DONE (ack falls)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= WB_IDLE;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          o_wb_ack <= 1'b0;
          if (i_wb_stb && i_wb_cyc) state_q <= i_wb_wen ? WB_WRITE : WB_READ;
        end
        WB_READ: begin
          o_wb_dat <= rdata_c;
          state_q  <= WB_ACK;
        end
        WB_WRITE: state_q <= WB_ACK;
        WB_ACK: begin
          o_wb_ack <= 1'b1;
          state_q  <= WB_DONE;
        end
        WB_DONE: begin
          o_wb_ack <= 1'b0;
          state_q  <= WB_IDLE;
        end
        default: begin
          o_wb_ack <= 1'b0;
          state_q  <= WB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed-vector bench for wb_timer with hand-computed expectations.
module tb_wb_timer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_adr = '0;
  logic        i_wb_stb = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_wen = 1'b0;
  logic [3:0]  i_wb_sel = '0;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_irq;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] A_CTRL  = 4'h0;
  localparam logic [3:0] A_LOAD  = 4'h4;
  localparam logic [3:0] A_VALUE = 4'h8;
  localparam logic [3:0] A_CLEAR = 4'hC;

  wb_timer dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wb_dat (i_wb_dat),
    .i_wb_adr (i_wb_adr),
    .i_wb_stb (i_wb_stb),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_wen (i_wb_wen),
    .i_wb_sel (i_wb_sel),
    .o_wb_dat (o_wb_dat),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge with the FSM idle; returns just after
  // the edge following the ack, with the FSM idle again.
  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata);
    int lat;
    lat = 0;
    i_wb_stb = 1'b1; i_wb_cyc = 1'b1; i_wb_wen = we;
    i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = sel;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge i_clk); #1;
      if (o_wb_ack) lat = i;
    end
    rdata = o_wb_dat;
    i_wb_stb = 1'b0; i_wb_cyc = 1'b0; i_wb_wen = 1'b0;
    check("ack_latency", 32'(lat), 32'd3);
    @(posedge i_clk); #1;
    check("ack_width", {31'b0, o_wb_ack}, 32'd0);
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    wb_xfer(1'b1, adr, dat, sel, unused_rd);
  endtask

  task automatic wb_read_chk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, 4'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic ack_seen;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst_ack", {31'b0, o_wb_ack}, 32'd0);
    check("rst_dat", o_wb_dat, 32'd0);
    check("rst_irq", {31'b0, o_irq}, 32'd0);
    wb_read_chk("rst_ctrl",  A_CTRL,  32'h0);
    wb_read_chk("rst_load",  A_LOAD,  32'h0);
    wb_read_chk("rst_value", A_VALUE, 32'h0);
    wb_read_chk("rst_clear", A_CLEAR, 32'h0);
    wb_read_chk("unmapped",  4'h2,    32'h0);

    // Periodic, PRESCALE=0, LOAD=5: CTRL applied at edge W, expiries W+6, W+12, W+18
    wb_write(A_LOAD, 32'd5, 4'hF);
    wb_write(A_CTRL, 32'h0000_0007, 4'hF);       // now after W+2
    cycles(4);                                   // after W+6: pending just set
    check("per_irq_lag", {31'b0, o_irq}, 32'd0);
    cycles(1);                                   // after W+7
    check("per_irq_rise", {31'b0, o_irq}, 32'd1);
    wb_write(A_CLEAR, 32'h1, 4'h1);              // clears at W+9, now after W+11
    check("per_irq_clr", {31'b0, o_irq}, 32'd0);
    cycles(1);                                   // after W+12
    check("per_irq_lag2", {31'b0, o_irq}, 32'd0);
    cycles(1);                                   // after W+13
    check("per_irq_rise2", {31'b0, o_irq}, 32'd1);
    wb_read_chk("per_val_a", A_VALUE, 32'd3);    // value after W+14
    wb_read_chk("per_val_b", A_VALUE, 32'd5);    // after W+18 reload
    wb_read_chk("per_val_c", A_VALUE, 32'd1);    // after W+22
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_write(A_CLEAR, 32'h1, 4'h1);
    wb_read_chk("per_pend_clr", A_CLEAR, 32'h0);

    // One-shot, LOAD=3: expiry at W+4
    wb_write(A_LOAD, 32'd3, 4'hF);
    wb_write(A_CTRL, 32'h0000_0005, 4'hF);
    cycles(4);
    check("os_irq", {31'b0, o_irq}, 32'd1);
    wb_read_chk("os_ctrl",  A_CTRL,  32'h0000_0004);
    wb_read_chk("os_value", A_VALUE, 32'h0);
    check("os_irq_hold", {31'b0, o_irq}, 32'd1);
    wb_read_chk("os_pend", A_CLEAR, 32'h1);
    wb_write(A_CLEAR, 32'h0, 4'h1);              // dat[0]=0 does not clear
    wb_read_chk("os_noclr", A_CLEAR, 32'h1);
    wb_write(A_CLEAR, 32'h1, 4'h1);
    check("os_irq_clr", {31'b0, o_irq}, 32'd0);
    wb_read_chk("os_pend_clr", A_CLEAR, 32'h0);

    // PRESCALE=3, LOAD=2: ticks every 4 clocks, expiry at W+12, then W+24
    wb_write(A_LOAD, 32'd2, 4'hF);
    wb_write(A_CTRL, 32'h0000_0307, 4'hF);       // now after W+2
    wb_read_chk("ps_val_a", A_VALUE, 32'd2);     // value after W+3
    wb_read_chk("ps_val_b", A_VALUE, 32'd1);     // value after W+7
    check("ps_irq_pre", {31'b0, o_irq}, 32'd0);  // after W+10
    cycles(2);                                   // after W+12
    check("ps_irq_lag", {31'b0, o_irq}, 32'd0);
    cycles(1);                                   // after W+13
    check("ps_irq_rise", {31'b0, o_irq}, 32'd1);

    // CLEAR landing on the W+24 expiry edge
    cycles(9);                                   // after W+22
    wb_write(A_CLEAR, 32'h1, 4'h1);              // applied at W+24
    wb_read_chk("sim_pend", A_CLEAR, 32'h1);
    check("sim_irq", {31'b0, o_irq}, 32'd1);

    // IE masking keeps pending
    wb_write(A_CTRL, 32'h0, 4'hF);
    check("mask_irq", {31'b0, o_irq}, 32'd0);
    wb_read_chk("mask_pend", A_CLEAR, 32'h1);
    wb_write(A_CTRL, 32'h0000_0004, 4'hF);
    check("unmask_irq", {31'b0, o_irq}, 32'd1);
    wb_read_chk("unmask_ctrl", A_CTRL, 32'h0000_0004);
    wb_write(A_CTRL, 32'hFFFF_00F8, 4'h9);       // only unimplemented bits set in enabled lanes
    wb_read_chk("ctrl_rsvd", A_CTRL, 32'h0000_0000);
    wb_write(A_CTRL, 32'h0000_0004, 4'h1);

    // Byte-select LOAD write
    wb_write(A_LOAD, 32'h1111_1111, 4'hF);
    wb_write(A_LOAD, 32'h0000_AB00, 4'b0010);
    wb_read_chk("bsel_load",  A_LOAD,  32'h1111_AB11);
    wb_read_chk("bsel_value", A_VALUE, 32'h1111_AB11);
    wb_write(A_VALUE, 32'h0, 4'hF);              // read-only, no effect
    wb_read_chk("ro_value", A_VALUE, 32'h1111_AB11);

    // Reset while in WRITE state
    i_wb_stb = 1'b1; i_wb_cyc = 1'b1; i_wb_wen = 1'b1;
    i_wb_adr = A_CTRL; i_wb_dat = 32'h0000_0007; i_wb_sel = 4'hF;
    @(posedge i_clk); #1;                        // FSM now in WRITE
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_wb_stb = 1'b0; i_wb_cyc = 1'b0; i_wb_wen = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      if (o_wb_ack) ack_seen = 1'b1;
    end
    check("mid_rst_ack", {31'b0, ack_seen}, 32'd0);
    check("mid_rst_irq", {31'b0, o_irq}, 32'd0);
    wb_read_chk("mid_rst_ctrl",  A_CTRL,  32'h0);
    wb_read_chk("mid_rst_load",  A_LOAD,  32'h0);
    wb_read_chk("mid_rst_value", A_VALUE, 32'h0);
    wb_read_chk("mid_rst_pend",  A_CLEAR, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
